hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of SRAM wait cycles after which sram_timeout is flagged.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low; it is the only reset.
REQ-005 forward_enable  input  1  forwarding path in EX active.
REQ-006 id_src1, id_src2  input  5 each  source registers of the instruction in ID.
REQ-007 id_two_src  input  1  ID instruction reads id_src2.
REQ-008 exe_dest  input  5; exe_wb  input  1; exe_mem_read  input  1  EX-stage destination, write-back and load flags.
REQ-009 mem_dest  input  5; mem_wb  input  1  MEM-stage destination and write-back flag.
REQ-010 mem_req  input  1  MEM stage issues an SRAM access; held high until sram_ready.
REQ-011 sram_ready  input  1  SRAM access completes this cycle.
REQ-012 freeze_pc, freeze_if_id  output  1 each  hold PC and IF/ID register.
REQ-013 bubble_id_ex  output  1  load a NOP into ID/EX.
REQ-014 freeze_all  output  1  hold every pipeline register; no bubble.
REQ-015 sram_timeout  output  1  sticky SRAM timeout flag.
REQ-016 stall_cnt  output  CNT_W  count of data-hazard stall cycles.

Function
REQ-017 "match(d)" SHALL mean d != 0 && (d == id_src1 || (id_two_src && d == id_src2)).
REQ-018 With forward_enable=1, data_hazard SHALL be exe_mem_read && match(exe_dest).
REQ-019 With forward_enable=0, data_hazard SHALL be (exe_wb && match(exe_dest)) || (mem_wb && match(mem_dest)).
REQ-020 freeze_all SHALL be combinational: mem_req && !sram_ready.
REQ-021 freeze_pc = freeze_if_id = bubble_id_ex SHALL equal data_hazard && !freeze_all; freeze_all takes priority and suppresses the bubble.
REQ-022 All hazard and freeze outputs SHALL be combinational; zero-cycle latency from inputs.
REQ-023 FSM states SHALL be IDLE and WAIT.
REQ-024 IDLE -> WAIT when mem_req && !sram_ready; otherwise remain IDLE.
REQ-025 WAIT -> IDLE when sram_ready or !mem_req; otherwise remain WAIT.
REQ-026 wait_cnt (internal, width clog2(TIMEOUT)+1) SHALL clear in IDLE, increment each cycle in WAIT, saturate at TIMEOUT.
REQ-027 sram_timeout SHALL set on the edge where wait_cnt reaches TIMEOUT while in WAIT, and stay set until reset.
REQ-028 Timeout SHALL NOT alter freeze_all; pipeline stays frozen until sram_ready.
REQ-029 stall_cnt SHALL increment by 1 on every rising edge where bubble_id_ex=1, and saturate at all-ones.
REQ-030 sram_ready asserted in the same cycle as mem_req (zero-wait) SHALL cause no freeze and no WAIT entry.
REQ-031 Register 0 SHALL never cause a hazard, whatever the flag values.

Reset
REQ-032 While rst=0, the FSM SHALL be IDLE, wait_cnt=0, sram_timeout=0 and stall_cnt=0, asynchronously.
REQ-033 Reset asserted during WAIT SHALL abort the wait immediately.
REQ-034 After reset release, combinational outputs SHALL follow inputs from the first cycle.

Verification
REQ-035 forward_enable=1, exe_mem_read=1, exe_dest=5, id_src1=5 -> freeze_pc=freeze_if_id=bubble_id_ex=1; stall_cnt 0->1 after one edge.
REQ-036 forward_enable=1, exe_wb=1, exe_mem_read=0, exe_dest=5, id_src2=5, id_two_src=1 -> no stall; same with forward_enable=0 -> stall.
REQ-037 exe_dest=0, exe_wb=1, id_src1=0 -> no stall in either forwarding mode.
REQ-038 mem_req=1, sram_ready=0 for 3 cycles then 1 -> freeze_all=1 for 3 cycles, then 0; FSM back in IDLE; concurrent data hazard gives bubble_id_ex=0 throughout the freeze.
REQ-039 TIMEOUT=4, mem_req=1, sram_ready=0 for 6 cycles -> sram_timeout=1 from the 5th edge onward, freeze_all stays 1; sram_timeout stays 1 after sram_ready.
REQ-040 rst pulled low mid-WAIT with stall_cnt=7 -> stall_cnt=0, sram_timeout=0, FSM in IDLE, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / no-forwarding data stalls, SRAM wait
// freeze with a sticky timeout flag, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_enable,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic             id_two_src,
   input  logic [4:0]       exe_dest,
   input  logic             exe_wb,
   input  logic             exe_mem_read,
   input  logic [4:0]       mem_dest,
   input  logic             mem_wb,
   input  logic             mem_req,
   input  logic             sram_ready,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             bubble_id_ex,
   output logic             freeze_all,
   output logic             sram_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WC_W = $clog2(TIMEOUT) + 1;
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);
   localparam logic [WC_W-1:0] WC_PRE = WC_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_next;
   logic [WC_W-1:0] wait_cnt;
   logic            data_hazard;
   logic            stall;

   // Register 0 is hard-wired zero, so it never carries a dependency.
   function automatic logic match(input logic [4:0] dest,
                                  input logic [4:0] src1,
                                  input logic [4:0] src2,
                                  input logic       two_src);
      return (dest != 5'd0) && ((dest == src1) || (two_src && (dest == src2)));
   endfunction

   always_comb begin
      data_hazard = 1'b0;
      if (forward_enable) begin
         data_hazard = exe_mem_read && match(exe_dest, id_src1, id_src2, id_two_src);
      end else begin
         data_hazard = (exe_wb && match(exe_dest, id_src1, id_src2, id_two_src)) ||
                       (mem_wb && match(mem_dest, id_src1, id_src2, id_two_src));
      end
   end

   // A frozen pipeline must not also inject a bubble, or the stalled
   // instruction in ID would be lost.
   always_comb begin
      freeze_all   = mem_req && !sram_ready;
      stall        = data_hazard && !freeze_all;
      freeze_pc    = stall;
      freeze_if_id = stall;
      bubble_id_ex = stall;
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE: if (mem_req && !sram_ready) state_next = WAIT;
         WAIT: if (sram_ready || !mem_req) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (state_q == IDLE) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WC_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Timeout only reports; the freeze is still released solely by sram_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_timeout <= 1'b0;
      end else if ((state_q == WAIT) && (wait_cnt >= WC_PRE)) begin
         sram_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
